// File: rtl/approx_error_monitor.sv
// approx_error_monitor
//   Watches a hybrid approximate adder/subtractor. For every accepted sample it
//   recomputes the exact result and forms the absolute error distance (ED)
//   against the adder's approximate output. Statistics are gathered over
//   WINDOW accepted samples and then offered as one report record.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous flush of pipeline, statistics and pending report
//   in_valid/in_ready sample handshake; in_a, in_b, in_sub, in_approx, in_approx_cout
//   rpt_valid/rpt_ready report handshake
//   rpt_samples, rpt_err_count, rpt_sum_abs_err (saturating), rpt_max_abs_err
module approx_error_monitor #(
  parameter int N      = 32,
  parameter int CNT_W  = 32,
  parameter int ACC_W  = 48,
  parameter int WINDOW = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_sub,
  input  logic [N-1:0]     in_approx,
  input  logic             in_approx_cout,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_samples,
  output logic [CNT_W-1:0] rpt_err_count,
  output logic [ACC_W-1:0] rpt_sum_abs_err,
  output logic [N:0]       rpt_max_abs_err
);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIN_M1 = CNT_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
  // S1: exact and presented results
  logic             s1_valid_q, s1_valid_d;
  logic [N:0]       e_q, e_d;
  logic [N:0]       p_q, p_d;
  // S2: error distance
  logic             s2_valid_q, s2_valid_d;
  logic [N:0]       ed_q, ed_d;
  // statistics
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [N:0]       max_q, max_d;

  logic             accept;
  logic [N:0]       e_calc;
  logic [N:0]       p_calc;
  logic [N:0]       ed_calc;
  logic [ACC_W:0]   sum_ext;

  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    rpt_valid = (state_q == ST_REPORT);
    accept    = in_valid && in_ready;

    // Subtract mode has no meaningful carry-out, so the presented value is
    // compared on N bits only (zero-extended).
    if (in_sub) begin
      e_calc = {1'b0, in_a - in_b};
      p_calc = {1'b0, in_approx};
    end else begin
      e_calc = {1'b0, in_a} + {1'b0, in_b};
      p_calc = {in_approx_cout, in_approx};
    end

    ed_calc = (p_q >= e_q) ? (p_q - e_q) : (e_q - p_q);
    // One extra bit catches accumulator overflow for saturation.
    sum_ext = {1'b0, sum_q} + {{(ACC_W - N){1'b0}}, ed_q};

    state_d      = state_q;
    accept_cnt_d = accept_cnt_q;
    s1_valid_d   = accept;
    e_d          = accept ? e_calc : e_q;
    p_d          = accept ? p_calc : p_q;
    s2_valid_d   = s1_valid_q;
    ed_d         = s1_valid_q ? ed_calc : ed_q;
    samples_d    = samples_q;
    err_count_d  = err_count_q;
    sum_d        = sum_q;
    max_d        = max_q;

    if (s2_valid_q) begin
      samples_d = samples_q + CNT_W'(1);
      if (ed_q != '0) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      sum_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      if (ed_q > max_q) begin
        max_d = ed_q;
      end
    end

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (accept_cnt_q == WIN_M1) begin
            accept_cnt_d = '0;
            state_d      = ST_DRAIN;
          end else begin
            accept_cnt_d = accept_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // No accepts happen in DRAIN, so once S1 is empty the final sample
        // sits in S2 and is folded into the statistics on this edge.
        if (!s1_valid_q) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (rpt_ready) begin
          samples_d   = '0;
          err_count_d = '0;
          sum_d       = '0;
          max_d       = '0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    // Flush wins over any accept, accumulation or report handshake.
    if (clear) begin
      state_d      = ST_ACCUM;
      accept_cnt_d = '0;
      s1_valid_d   = 1'b0;
      s2_valid_d   = 1'b0;
      samples_d    = '0;
      err_count_d  = '0;
      sum_d        = '0;
      max_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      accept_cnt_q <= '0;
      s1_valid_q   <= 1'b0;
      e_q          <= '0;
      p_q          <= '0;
      s2_valid_q   <= 1'b0;
      ed_q         <= '0;
      samples_q    <= '0;
      err_count_q  <= '0;
      sum_q        <= '0;
      max_q        <= '0;
    end else begin
      state_q      <= state_d;
      accept_cnt_q <= accept_cnt_d;
      s1_valid_q   <= s1_valid_d;
      e_q          <= e_d;
      p_q          <= p_d;
      s2_valid_q   <= s2_valid_d;
      ed_q         <= ed_d;
      samples_q    <= samples_d;
      err_count_q  <= err_count_d;
      sum_q        <= sum_d;
      max_q        <= max_d;
    end
  end

  assign rpt_samples     = samples_q;
  assign rpt_err_count   = err_count_q;
  assign rpt_sum_abs_err = sum_q;
  assign rpt_max_abs_err = max_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Testbench for approx_error_monitor: N=8, WINDOW=4, ACC_W=9 so that the sum
// accumulator saturates easily. The driver keeps a window of expected error
// distances and pushes a full report record into a queue once WINDOW samples
// have been accepted; the monitor pops and compares whenever a report is shown.
module tb_approx_error_monitor;
  localparam int N       = 8;
  localparam int CNT_W   = 8;
  localparam int ACC_W   = 9;
  localparam int WINDOW  = 4;
  localparam int SUM_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_b = '0;
  logic             in_sub = 1'b0;
  logic [N-1:0]     in_approx = '0;
  logic             in_approx_cout = 1'b0;
  logic             rpt_valid;
  logic             rpt_ready = 1'b0;
  logic [CNT_W-1:0] rpt_samples;
  logic [CNT_W-1:0] rpt_err_count;
  logic [ACC_W-1:0] rpt_sum_abs_err;
  logic [N:0]       rpt_max_abs_err;

  approx_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .in_approx(in_approx), .in_approx_cout(in_approx_cout),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_samples(rpt_samples), .rpt_err_count(rpt_err_count),
    .rpt_sum_abs_err(rpt_sum_abs_err), .rpt_max_abs_err(rpt_max_abs_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int samples;
    int errs;
    int sum;
    int maxv;
  } rpt_t;

  rpt_t exp_q[$];
  int   win_ed[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;   // 0: ready high, 1: random, 2: held low
  bit   prev_hs = 1'b0;

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, expv, $time);
  endtask

  // Reference error distance straight from the arithmetic definition.
  function automatic int ed_of(input int a, input int b, input bit sub, input int ap, input bit co);
    int e;
    int p;
    if (sub) begin
      e = a - b;
      if (e < 0) e += (1 << N);
      p = ap;
    end else begin
      e = a + b;
      p = ap + (co ? (1 << N) : 0);
    end
    return (p >= e) ? (p - e) : (e - p);
  endfunction

  task automatic close_window();
    rpt_t r;
    r.samples = WINDOW;
    r.errs = 0;
    r.sum = 0;
    r.maxv = 0;
    foreach (win_ed[i]) begin
      if (win_ed[i] != 0) r.errs++;
      r.sum += win_ed[i];
      if (win_ed[i] > r.maxv) r.maxv = win_ed[i];
    end
    if (r.sum > SUM_MAX) r.sum = SUM_MAX;
    exp_q.push_back(r);
    win_ed.delete();
  endtask

  // Called just after a rising edge: applies inputs for one cycle.
  task automatic drive(input bit v, input int a, input int b, input bit sub,
                       input int ap, input bit co, input bit clr);
    bit model_ready;
    bit acc;
    in_valid       = v;
    in_a           = a[N-1:0];
    in_b           = b[N-1:0];
    in_sub         = sub;
    in_approx      = ap[N-1:0];
    in_approx_cout = co;
    clear          = clr;
    case (rdy_mode)
      0:       rpt_ready = 1'b1;
      1:       rpt_ready = 1'($urandom_range(0, 1));
      default: rpt_ready = 1'b0;
    endcase
    model_ready = (exp_q.size() == 0);
    chk("in_ready", int'(in_ready), int'(model_ready));
    acc = v && model_ready && !clr;
    @(posedge clk);
    #1;
    if (clr) begin
      win_ed.delete();
    end else if (acc) begin
      win_ed.push_back(ed_of(a, b, sub, ap, co));
      if (win_ed.size() == WINDOW) close_window();
    end
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic send_rand(input bit exact, input bit clr);
    int a;
    int b;
    int e;
    int ap;
    bit sub;
    bit co;
    int sel;
    a   = int'($urandom_range(0, 255));
    b   = int'($urandom_range(0, 255));
    sub = 1'($urandom_range(0, 1));
    e   = sub ? ((a - b) & 255) : (a + b);
    ap  = e & 255;
    co  = sub ? 1'($urandom_range(0, 1)) : 1'(e >> 8);
    sel = exact ? 0 : int'($urandom_range(0, 3));
    case (sel)
      1: ap = (e ^ int'($urandom_range(0, 15))) & 255;
      2: ap = int'($urandom_range(0, 255));
      3: co = ~co;
      default: ;
    endcase
    drive(1'b1, a, b, sub, ap, co, clr);
  endtask

  task automatic wait_reports();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      idle();
      k++;
    end
    chk("report_drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    win_ed.delete();
    exp_q.delete();
    chk("rst_rpt_valid", int'(rpt_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_samples", int'(rpt_samples), 0);
    chk("rst_err_count", int'(rpt_err_count), 0);
    chk("rst_sum", int'(rpt_sum_abs_err), 0);
    chk("rst_max", int'(rpt_max_abs_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every displayed report against the queue head and
  // retires it on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_hs) chk("rpt_valid_after_hs", int'(rpt_valid), 0);
      prev_hs = 1'b0;
      if (rst_n && rpt_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rpt_unexpected got=valid exp=none t=%0t", $time);
        end else begin
          chk("rpt_samples", int'(rpt_samples), exp_q[0].samples);
          chk("rpt_err_count", int'(rpt_err_count), exp_q[0].errs);
          chk("rpt_sum", int'(rpt_sum_abs_err), exp_q[0].sum);
          chk("rpt_max", int'(rpt_max_abs_err), exp_q[0].maxv);
          if (rpt_ready && !clear) begin
            void'(exp_q.pop_front());
            prev_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // exact results: no error at all
    rdy_mode = 0;
    repeat (WINDOW) send_rand(1'b1, 1'b0);
    wait_reports();

    // add 200+100 with exact and off-by-4 results
    drive(1'b1, 200, 100, 1'b0, 8'h2C, 1'b1, 1'b0);
    drive(1'b1, 200, 100, 1'b0, 8'h28, 1'b1, 1'b0);
    drive(1'b1, 1, 2, 1'b0, 3, 1'b0, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    wait_reports();

    // subtract 5-10, carry-out must be ignored
    drive(1'b1, 5, 10, 1'b1, 8'hF9, 1'b1, 1'b0);
    drive(1'b1, 10, 5, 1'b1, 5, 1'b1, 1'b0);
    drive(1'b1, 0, 1, 1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 7, 7, 1'b1, 0, 1'b1, 1'b0);
    wait_reports();

    // consumer stalls with in_valid held high
    rdy_mode = 2;
    repeat (10) send_rand(1'b0, 1'b0);
    rdy_mode = 0;
    repeat (6) send_rand(1'b0, 1'b0);
    wait_reports();

    // maximum ED on every sample: accumulator saturates
    repeat (WINDOW) drive(1'b1, 0, 0, 1'b0, 8'hFF, 1'b1, 1'b0);
    wait_reports();

    // clear after two accepts; the sample offered with clear is dropped
    send_rand(1'b0, 1'b0);
    send_rand(1'b0, 1'b0);
    send_rand(1'b0, 1'b1);
    repeat (WINDOW) send_rand(1'b0, 1'b0);
    wait_reports();

    // reset mid-window
    send_rand(1'b0, 1'b0);
    send_rand(1'b0, 1'b0);
    do_reset();
    repeat (WINDOW) send_rand(1'b0, 1'b0);
    wait_reports();

    // reset while a report is pending
    rdy_mode = 2;
    repeat (WINDOW) send_rand(1'b0, 1'b0);
    k = 0;
    while (!rpt_valid && k < 10) begin
      idle();
      k++;
    end
    chk("pending_report_seen", int'(rpt_valid), 1);
    do_reset();
    rdy_mode = 0;
    repeat (WINDOW) send_rand(1'b0, 1'b0);
    wait_reports();

    // random traffic with random back-pressure and occasional clears
    rdy_mode = 1;
    for (int i = 0; i < 500; i++) begin
      bit clr;
      clr = (exp_q.size() == 0) && ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) != 0) send_rand(1'b0, clr);
      else drive(1'b0, 0, 0, 1'b0, 0, 1'b0, clr);
    end
    rdy_mode = 0;
    wait_reports();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
